// File: rtl/llc_pkg.sv
// Shared trace-command encoding, event bundle and default sizing for the LLC front end.
package llc_pkg;

  localparam int unsigned LlcDepth = 4;
  localparam int unsigned LlcAw    = 32;

  typedef enum logic [3:0] {
    CmdPrRd    = 4'd0,
    CmdPrWr    = 4'd1,
    CmdIfetch  = 4'd2,
    CmdBusUpgr = 4'd3,
    CmdBusRd   = 4'd4,
    CmdNop     = 4'd5,
    CmdBusRdx  = 4'd6,
    CmdClear   = 4'd8,
    CmdPrint   = 4'd9
  } llc_cmd_e;

  typedef struct packed {
    logic pr_rd;
    logic pr_wr;
    logic bus_rd;
    logic bus_rdx;
    logic bus_upgr;
    logic instr;
    logic clear_all;
    logic print_req;
  } llc_ev_t;

  // Codes 7 and 10-15 have no meaning in the trace format.
  function automatic logic llc_is_illegal(input logic [3:0] code);
    return (code == 4'd7) || (code >= 4'd10);
  endfunction

  function automatic llc_ev_t llc_decode(input logic [3:0] code);
    llc_ev_t ev;
    ev = '0;
    case (code)
      CmdPrRd:    ev.pr_rd = 1'b1;
      CmdPrWr:    ev.pr_wr = 1'b1;
      CmdIfetch: begin
        ev.pr_rd = 1'b1;
        ev.instr = 1'b1;
      end
      CmdBusUpgr: ev.bus_upgr  = 1'b1;
      CmdBusRd:   ev.bus_rd    = 1'b1;
      CmdBusRdx:  ev.bus_rdx   = 1'b1;
      CmdClear:   ev.clear_all = 1'b1;
      CmdPrint:   ev.print_req = 1'b1;
      default:    ev = '0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/llc_cmd_fifo.sv
// Command FIFO with occupancy counter; read data is the head entry (show-ahead).
module llc_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/llc_cmd_decoder.sv
// Buffers trace commands and turns each popped entry into one registered MESI event pulse.
module llc_cmd_decoder
  import llc_pkg::*;
#(
  parameter int unsigned DEPTH = LlcDepth,
  parameter int unsigned AW    = LlcAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [3:0]    cmd,
  input  logic [AW-1:0] cmd_addr,
  output logic          cmd_ready,
  input  logic          mesi_ready,
  output logic          PrRd,
  output logic          PrWr,
  output logic          BusRd,
  output logic          BusRdx,
  output logic          BusUpgr,
  output logic          instr,
  output logic [AW-1:0] ev_addr,
  output logic          clear_all,
  output logic          print_req,
  output logic [7:0]    illegal_cnt
);

  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [AW+3:0] fifo_rdata;
  logic [3:0]    head_cmd;
  logic [AW-1:0] head_addr;

  llc_ev_t       ev_q, ev_d;
  logic [AW-1:0] ev_addr_q, ev_addr_d;
  logic [7:0]    illegal_cnt_q, illegal_cnt_d;

  // Gated by rst so upstream sees "not ready" for the whole reset window.
  assign cmd_ready = ~fifo_full & rst;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = ~fifo_empty & mesi_ready;
  assign head_cmd  = fifo_rdata[AW+3:AW];
  assign head_addr = fifo_rdata[AW-1:0];

  llc_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + 4)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i ({cmd, cmd_addr}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    ev_d          = '0;
    ev_addr_d     = ev_addr_q;
    illegal_cnt_d = illegal_cnt_q;
    if (pop) begin
      ev_d      = llc_decode(head_cmd);
      ev_addr_d = head_addr;
      if (llc_is_illegal(head_cmd) && (illegal_cnt_q != 8'hff)) begin
        illegal_cnt_d = illegal_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_q          <= '0;
      ev_addr_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      ev_q          <= ev_d;
      ev_addr_q     <= ev_addr_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign PrRd        = ev_q.pr_rd;
  assign PrWr        = ev_q.pr_wr;
  assign BusRd       = ev_q.bus_rd;
  assign BusRdx      = ev_q.bus_rdx;
  assign BusUpgr     = ev_q.bus_upgr;
  assign instr       = ev_q.instr;
  assign clear_all   = ev_q.clear_all;
  assign print_req   = ev_q.print_req;
  assign ev_addr     = ev_addr_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_llc_cmd_decoder.sv
// Bench for llc_cmd_decoder: decode table, directed corner sequences, random traffic vs queue model.
`timescale 1ns/1ps
module tb_llc_cmd_decoder;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  // Pulse vector order: {PrRd, PrWr, BusRd, BusRdx, BusUpgr, instr, clear_all, print_req}
  localparam logic [7:0] EvPrRd  = 8'h80;
  localparam logic [7:0] EvPrWr  = 8'h40;
  localparam logic [7:0] EvBusRd = 8'h20;
  localparam logic [7:0] EvBusRx = 8'h10;
  localparam logic [7:0] EvBusUp = 8'h08;
  localparam logic [7:0] EvInstr = 8'h04;
  localparam logic [7:0] EvClear = 8'h02;
  localparam logic [7:0] EvPrint = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic          mesi_ready = 1'b0;
  logic          cmd_ready;
  logic          PrRd, PrWr, BusRd, BusRdx, BusUpgr, instr, clear_all, print_req;
  logic [AW-1:0] ev_addr;
  logic [7:0]    illegal_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  llc_cmd_decoder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_addr    (cmd_addr),
    .cmd_ready   (cmd_ready),
    .mesi_ready  (mesi_ready),
    .PrRd        (PrRd),
    .PrWr        (PrWr),
    .BusRd       (BusRd),
    .BusRdx      (BusRdx),
    .BusUpgr     (BusUpgr),
    .instr       (instr),
    .ev_addr     (ev_addr),
    .clear_all   (clear_all),
    .print_req   (print_req),
    .illegal_cnt (illegal_cnt)
  );

  // Reference model: queue of pending commands plus last expected outputs.
  typedef struct packed {
    logic [3:0]    code;
    logic [AW-1:0] addr;
  } ent_t;

  ent_t          mq[$];
  logic [7:0]    m_pulse = 8'h00;
  logic [AW-1:0] m_addr = '0;
  int            m_ill = 0;

  typedef struct {
    logic [3:0]    code;
    logic [AW-1:0] addr;
    logic [7:0]    exp;
  } vec_t;

  vec_t tbl[16] = '{
    '{4'd0,  32'h0000_1040, 8'h80}, '{4'd1,  32'h0000_2044, 8'h40},
    '{4'd2,  32'h0000_3048, 8'h84}, '{4'd3,  32'h0000_404c, 8'h08},
    '{4'd4,  32'h0000_5050, 8'h20}, '{4'd5,  32'h0000_6054, 8'h00},
    '{4'd6,  32'h0000_7058, 8'h10}, '{4'd7,  32'h0000_805c, 8'h00},
    '{4'd8,  32'h0000_9060, 8'h02}, '{4'd9,  32'h0000_a064, 8'h01},
    '{4'd10, 32'h0000_b068, 8'h00}, '{4'd11, 32'h0000_c06c, 8'h00},
    '{4'd12, 32'h0000_d070, 8'h00}, '{4'd13, 32'h0000_e074, 8'h00},
    '{4'd14, 32'h0000_f078, 8'h00}, '{4'd15, 32'hdead_beef, 8'h00}
  };

  function automatic logic [7:0] spec_pulses(input logic [3:0] c);
    case (c)
      4'd0:    return EvPrRd;
      4'd1:    return EvPrWr;
      4'd2:    return EvPrRd | EvInstr;
      4'd3:    return EvBusUp;
      4'd4:    return EvBusRd;
      4'd6:    return EvBusRx;
      4'd8:    return EvClear;
      4'd9:    return EvPrint;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] c);
    return (c == 4'd7) || (c >= 4'd10);
  endfunction

  function automatic logic [7:0] pulses_now();
    return {PrRd, PrWr, BusRd, BusRdx, BusUpgr, instr, clear_all, print_req};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance model, compare registered outputs after the edge.
  task automatic step(input logic v, input logic [3:0] c, input logic [AW-1:0] a, input logic mr);
    ent_t e;
    logic rdy;
    logic popped;
    cmd_valid  = v;
    cmd        = c;
    cmd_addr   = a;
    mesi_ready = mr;
    rdy = (mq.size() < DEPTH);
    check("cmd_ready", 64'(cmd_ready), 64'(rdy));
    popped  = (mq.size() != 0) && (mr == 1'b1);
    m_pulse = 8'h00;
    if (popped) begin
      e       = mq.pop_front();
      m_pulse = spec_pulses(e.code);
      m_addr  = e.addr;
      if (is_illegal(e.code) && (m_ill < 255)) m_ill++;
    end
    if ((v == 1'b1) && rdy) mq.push_back({c, a});
    @(posedge clk);
    #1;
    check("pulses", 64'(pulses_now()), 64'(m_pulse));
    check("ev_addr", 64'(ev_addr), 64'(m_addr));
    check("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
  endtask

  // Called 1ns after a rising edge; returns 2ns after a later rising edge with rst released.
  task automatic apply_reset();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #2;
    check("rst_pulses", 64'(pulses_now()), 64'h0);
    check("rst_ev_addr", 64'(ev_addr), 64'h0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'h0);
    check("rst_cmd_ready_low", 64'(cmd_ready), 64'h0);
    mq.delete();
    m_pulse = 8'h00;
    m_addr  = '0;
    m_ill   = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rel_cmd_ready", 64'(cmd_ready), 64'h1);
  endtask

  logic [3:0] seq_code[7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9};
  logic [7:0] seq_exp[7]  = '{8'h40, 8'h84, 8'h08, 8'h20, 8'h10, 8'h02, 8'h01};
  logic [3:0] full_code[5] = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd3};
  logic [7:0] full_exp[5]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h00};
  logic [3:0] ovl_code[4]  = '{4'd1, 4'd3, 4'd4, 4'd6};
  logic [7:0] ovl_exp[4]   = '{8'h08, 8'h20, 8'h10, 8'h00};

  initial begin
    @(posedge clk);
    #1;
    apply_reset();

    // Decode table, one command at a time from empty: pulse lands two cycles after accept.
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].code, tbl[i].addr, 1'b1);
      check($sformatf("tbl_lat_code%0d", tbl[i].code), 64'(pulses_now()), 64'h0);
      step(1'b0, 4'd0, '0, 1'b1);
      check($sformatf("tbl_pulse_code%0d", tbl[i].code), 64'(pulses_now()), 64'(tbl[i].exp));
      check($sformatf("tbl_addr_code%0d", tbl[i].code), 64'(ev_addr), 64'(tbl[i].addr));
    end

    // Back-to-back legal commands give pulses on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      if (i < 7) step(1'b1, seq_code[i], 32'h2000 + 32'(i * 4), 1'b1);
      else       step(1'b0, 4'd0, '0, 1'b1);
      if (i >= 1) check($sformatf("b2b_%0d", i - 1), 64'(pulses_now()), 64'(seq_exp[i - 1]));
    end

    // Stall downstream, overfill by one, then drain in order.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, full_code[i], 32'h3000 + 32'(i * 16), 1'b0);
      if (i >= 3) check($sformatf("full_ready_%0d", i), 64'(cmd_ready), 64'h0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, '0, 1'b1);
      check($sformatf("drain_%0d", i), 64'(pulses_now()), 64'(full_exp[i]));
    end

    // Full FIFO with simultaneous push and pop: push refused, slot frees next cycle.
    for (int i = 0; i < 4; i++) step(1'b1, ovl_code[i], 32'h4000 + 32'(i * 16), 1'b0);
    step(1'b1, 4'd9, 32'h0000_9999, 1'b1);
    check("ovl_first", 64'(pulses_now()), 64'(EvPrWr));
    check("ovl_ready_next", 64'(cmd_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, '0, 1'b1);
      check($sformatf("ovl_drain_%0d", i), 64'(pulses_now()), 64'(ovl_exp[i]));
    end

    // Illegal codes: counted, no pulses, saturating.
    apply_reset();
    step(1'b1, 4'd7, 32'h5000, 1'b1);
    step(1'b1, 4'hf, 32'h5004, 1'b1);
    step(1'b0, 4'd0, '0, 1'b1);
    check("ill_two", 64'(illegal_cnt), 64'd2);
    for (int i = 0; i < 258; i++) begin
      int unsigned c;
      c = $urandom_range(10, 16);
      if (c == 16) c = 7;
      step(1'b1, 4'(c), $urandom, 1'b1);
      check("ill_no_pulse", 64'(pulses_now()), 64'h0);
    end
    step(1'b0, 4'd0, '0, 1'b1);
    check("ill_saturated", 64'(illegal_cnt), 64'd255);

    // Reset while commands are queued and a pulse is high.
    step(1'b1, 4'd1, 32'h6000, 1'b1);
    step(1'b1, 4'd0, 32'h6010, 1'b0);
    step(1'b1, 4'd0, 32'h6020, 1'b0);
    step(1'b1, 4'd4, 32'h6030, 1'b1);
    check("pre_rst_pulse", 64'(pulses_now()), 64'(EvPrWr));
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, '0, 1'b1);
      check("post_rst_quiet", 64'(pulses_now()), 64'h0);
    end

    // Random traffic against the queue model, with varying downstream pressure.
    for (int i = 0; i < 3000; i++) begin
      int unsigned mr_pct;
      mr_pct = ((i / 200) % 3 == 0) ? 20 : 70;
      if (i == 1500) apply_reset();
      step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 99) < mr_pct) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
